// File: rtl/am2901_useq_pkg.sv
// Shared definitions for the Am2901 microprogram sequencer: op codes,
// microword field offsets, the datapath NOP opcode and the FSM encoding.
package am2901_useq_pkg;

    localparam logic [3:0] OP_CONT = 4'd0;
    localparam logic [3:0] OP_JUMP = 4'd1;
    localparam logic [3:0] OP_JZ   = 4'd2;
    localparam logic [3:0] OP_JNZ  = 4'd3;
    localparam logic [3:0] OP_JC   = 4'd4;
    localparam logic [3:0] OP_JOV  = 4'd5;
    localparam logic [3:0] OP_CALL = 4'd6;
    localparam logic [3:0] OP_RET  = 4'd7;
    localparam logic [3:0] OP_LDCT = 4'd8;
    localparam logic [3:0] OP_RPCT = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd10;

    localparam int I_LSB   = 0;
    localparam int A_LSB   = 9;
    localparam int B_LSB   = 13;
    localparam int D_LSB   = 17;
    localparam int CIN_BIT = 21;
    localparam int OE_BIT  = 22;
    localparam int OP_LSB  = 23;
    localparam int BR_LSB  = 27;

    // ALU source/function with destination "no register, no Q write"
    localparam logic [8:0] I_NOP = 9'b001_000_000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_DONE
    } state_t;

endpackage

// File: rtl/am2901_useq_stack.sv
// Return-address LIFO for the sequencer: STK_D entries of UA_W bits.
// Overflow/underflow are refused here and reported to the caller via full/empty.
module useq_stack #(
    parameter int UA_W  = 6,
    parameter int STK_D = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [UA_W-1:0] din,
    output logic [UA_W-1:0] top,
    output logic            full,
    output logic            empty
);

    localparam int SP_W  = $clog2(STK_D + 1);
    localparam int IDX_W = (STK_D > 1) ? $clog2(STK_D) : 1;

    logic [UA_W-1:0] mem [STK_D];
    logic [SP_W-1:0] sp;
    logic [IDX_W-1:0] top_idx;

    assign full    = (sp == SP_W'(STK_D));
    assign empty   = (sp == '0);
    assign top_idx = IDX_W'(sp - SP_W'(1));
    assign top     = mem[top_idx];

    // Stack pointer: flush and reset both empty the stack
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Entry storage: written on an accepted push only
    always_ff @(posedge clk) begin
        if (push && !full && !flush) begin
            mem[IDX_W'(sp)] <= din;
        end
    end

endmodule

// File: rtl/am2901_useq.sv
// Am2910-lite microprogram sequencer: fetches microwords from a synchronous
// micro-ROM, issues the Am2901 datapath fields and computes the next address.
module am2901_useq
    import am2901_useq_pkg::*;
#(
    parameter int UA_W   = 6,
    parameter int CNT_W  = 8,
    parameter int STK_D  = 4,
    parameter int WORD_W = 27 + UA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [UA_W-1:0]   start_addr,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [UA_W-1:0]   uaddr,
    input  logic [WORD_W-1:0] uword,
    output logic [8:0]        i,
    output logic [3:0]        a,
    output logic [3:0]        b,
    output logic [3:0]        d,
    output logic              cin,
    output logic              oe,
    input  logic              z,
    input  logic              ovr,
    input  logic              c4
);

    state_t          state;
    logic [UA_W-1:0] upc;
    logic [CNT_W-1:0] cnt;

    logic [3:0]      op;
    logic [UA_W-1:0] br;
    logic [UA_W-1:0] nxt;
    logic            fault;
    logic            halt;
    logic            push_req;
    logic            pop_req;
    logic            in_exec;
    logic            start_ok;
    logic [UA_W-1:0] stk_top;
    logic            stk_full;
    logic            stk_empty;

    assign op       = uword[OP_LSB +: 4];
    assign br       = uword[BR_LSB +: UA_W];
    assign in_exec  = (state == ST_EXEC) && !abort;
    assign start_ok = (state == ST_IDLE) && start && !abort;
    assign busy     = (state == ST_FETCH) || (state == ST_EXEC);
    assign done     = (state == ST_DONE);

    // A stale return stack must not leak into a new program, so it is also
    // emptied whenever a start is accepted.
    useq_stack #(
        .UA_W  (UA_W),
        .STK_D (STK_D)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_exec && push_req),
        .pop   (in_exec && pop_req),
        .flush (abort || start_ok),
        .din   (upc + UA_W'(1)),
        .top   (stk_top),
        .full  (stk_full),
        .empty (stk_empty)
    );

    // Next-address selection and fault/halt decode for the current microword
    always_comb begin
        nxt      = upc + UA_W'(1);
        fault    = 1'b0;
        halt     = 1'b0;
        push_req = 1'b0;
        pop_req  = 1'b0;
        case (op)
            OP_CONT, OP_LDCT: ;
            OP_JUMP: nxt = br;
            OP_JZ:   if (z)    nxt = br;
            OP_JNZ:  if (!z)   nxt = br;
            OP_JC:   if (c4)   nxt = br;
            OP_JOV:  if (ovr)  nxt = br;
            OP_CALL: begin
                if (stk_full) begin
                    fault = 1'b1;
                end else begin
                    push_req = 1'b1;
                    nxt      = br;
                end
            end
            OP_RET: begin
                if (stk_empty) begin
                    fault = 1'b1;
                end else begin
                    pop_req = 1'b1;
                    nxt     = stk_top;
                end
            end
            OP_RPCT: if (cnt != '0) nxt = br;
            OP_HALT: halt = 1'b1;
            default: fault = 1'b1;
        endcase
    end

    // ROM address and datapath fields; NOP everywhere except a live EXEC cycle
    always_comb begin
        uaddr = '0;
        i     = I_NOP;
        a     = '0;
        b     = '0;
        d     = '0;
        cin   = 1'b0;
        oe    = 1'b0;
        if (!abort) begin
            case (state)
                ST_IDLE:  if (start) uaddr = start_addr;
                ST_FETCH: uaddr = upc;
                ST_EXEC: begin
                    uaddr = nxt;
                    i     = uword[I_LSB +: 9];
                    a     = uword[A_LSB +: 4];
                    b     = uword[B_LSB +: 4];
                    d     = uword[D_LSB +: 4];
                    cin   = uword[CIN_BIT];
                    oe    = uword[OE_BIT];
                end
                default: ;
            endcase
        end
    end

    // Sequencer state machine; abort overrides everything except reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            upc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else if (abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        upc   <= start_addr;
                        err   <= 1'b0;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    upc <= nxt;
                    if (op == OP_LDCT) begin
                        cnt <= CNT_W'(br);
                    end else if (op == OP_RPCT && cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                    if (fault) begin
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else if (halt) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_am2901_useq.sv
// Directed, table-driven bench for am2901_useq with a 1-cycle synchronous ROM model.
module tb_am2901_useq;
    import am2901_useq_pkg::*;

    localparam int UA_W   = 6;
    localparam int CNT_W  = 8;
    localparam int STK_D  = 4;
    localparam int WORD_W = 27 + UA_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, start, abort, z, ovr, c4;
    logic [UA_W-1:0]   start_addr, uaddr;
    logic              busy, done, err;
    logic [WORD_W-1:0] uword;
    logic [8:0]        i;
    logic [3:0]        a, b, d;
    logic              cin, oe;

    logic [WORD_W-1:0] rom [64];
    always @(posedge clk) uword <= rom[uaddr];

    am2901_useq #(.UA_W(UA_W), .CNT_W(CNT_W), .STK_D(STK_D)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .abort(abort), .busy(busy), .done(done), .err(err), .uaddr(uaddr),
        .uword(uword), .i(i), .a(a), .b(b), .d(d), .cin(cin), .oe(oe),
        .z(z), .ovr(ovr), .c4(c4)
    );

    typedef struct {
        logic       rn, st, ab;
        logic [2:0] flg;          // {z, c4, ovr}
        logic [5:0] sa;
        logic       xb, xd, xe;
        int         xua;          // -1: not checked
        int         xw;           // ROM address whose fields must appear; -1 NOP; -2 not checked
    } vec_t;

    typedef struct {
        logic [3:0] op;
        int         flg;
        int         taken;
    } br_t;

    vec_t vq[$];
    br_t  bt[9];
    int   loop_tr[10] = '{48, 49, 50, 49, 50, 49, 50, 49, 50, 51};
    int   n_chk  = 0;
    int   n_fail = 0;

    // Microword: distinct i/a/b/d/cin per address, oe always 1
    function automatic logic [WORD_W-1:0] mk(input int addr, input logic [3:0] op, input int br);
        logic [5:0] ad;
        ad = 6'(addr);
        mk = {6'(br), op, 1'b1, ad[0], ad[5:2], ~ad[3:0], ad[3:0], 3'b011, ad};
    endfunction

    function automatic logic [22:0] exp_dp(input int w);
        if (w < 0) exp_dp = {1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 9'b001_000_000};
        else       exp_dp = rom[w][22:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input int st, input int sa, input int ab, input int flg,
                       input int xb, input int xd, input int xe, input int xua, input int xw,
                       input int rn = 1);
        vec_t v;
        v.rn = (rn != 0); v.st = (st != 0); v.ab = (ab != 0); v.flg = 3'(flg);
        v.sa = 6'(sa); v.xb = (xb != 0); v.xd = (xd != 0); v.xe = (xe != 0);
        v.xua = xua; v.xw = xw;
        vq.push_back(v);
    endtask

    task automatic prog_start(input int sa, input int eb);
        add(1, sa, 0, 0, 0, 0, eb, sa, -1);
        add(0, 0, 0, 0, 1, 0, 0, sa, -1);
    endtask

    task automatic ex(input int nxt, input int w, input int flg = 0);
        add(0, 0, 0, flg, 1, 0, 0, nxt, w);
    endtask

    task automatic prog_end(input int e);
        add(0, 0, 0, 0, 0, 1, e, 0, -1);
        add(0, 0, 0, 0, 0, 0, e, 0, -1);
    endtask

    task automatic run_vecs(input string sect);
        for (int k = 0; k < vq.size(); k++) begin
            @(posedge clk); #1;
            rst_n = vq[k].rn; start = vq[k].st; start_addr = vq[k].sa; abort = vq[k].ab;
            {z, c4, ovr} = vq[k].flg;
            @(negedge clk);
            chk($sformatf("%s.busy[%0d]", sect, k), 32'(busy), 32'(vq[k].xb));
            chk($sformatf("%s.done[%0d]", sect, k), 32'(done), 32'(vq[k].xd));
            chk($sformatf("%s.err[%0d]", sect, k), 32'(err), 32'(vq[k].xe));
            if (vq[k].xua >= 0)
                chk($sformatf("%s.uaddr[%0d]", sect, k), 32'(uaddr), 32'(vq[k].xua));
            if (vq[k].xw != -2)
                chk($sformatf("%s.dp[%0d]", sect, k), 32'({oe, cin, d, b, a, i}), 32'(exp_dp(vq[k].xw)));
        end
        vq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_addr = '0;
        z = 1'b0; c4 = 1'b0; ovr = 1'b0;
        for (int k = 0; k < 64; k++) rom[k] = mk(k, OP_HALT, 0);
        rom[5]  = mk(5, OP_CONT, 0);
        rom[6]  = mk(6, OP_CONT, 0);
        rom[10] = mk(10, OP_CALL, 30);
        rom[30] = mk(30, OP_RET, 0);
        rom[40] = mk(40, 4'd12, 0);
        rom[45] = mk(45, OP_RET, 0);
        rom[48] = mk(48, OP_LDCT, 3);
        rom[49] = mk(49, OP_CONT, 0);
        rom[50] = mk(50, OP_RPCT, 49);
        for (int k = 56; k <= 60; k++) rom[k] = mk(k, OP_CALL, k + 1);
        bt[0] = '{OP_JZ,   'b100, 1};
        bt[1] = '{OP_JZ,   'b011, 0};
        bt[2] = '{OP_JNZ,  'b000, 1};
        bt[3] = '{OP_JNZ,  'b100, 0};
        bt[4] = '{OP_JC,   'b010, 1};
        bt[5] = '{OP_JC,   'b101, 0};
        bt[6] = '{OP_JOV,  'b001, 1};
        bt[7] = '{OP_JOV,  'b110, 0};
        bt[8] = '{OP_JUMP, 'b000, 1};
        repeat (3) @(posedge clk);

        // Reset state
        add(0, 0, 0, 0, 0, 0, 0, 0, -1);
        add(0, 0, 0, 0, 0, 0, 0, 0, -1);
        run_vecs("reset");

        // Straight line 5,6,7; a start during DONE is ignored
        prog_start(5, 0);
        ex(6, 5); ex(7, 6); ex(8, 7);
        add(1, 5, 0, 0, 0, 1, 0, 0, -1);
        add(0, 0, 0, 0, 0, 0, 0, 0, -1);
        add(0, 0, 0, 0, 0, 0, 0, 0, -1);
        run_vecs("straight");

        // Conditional and unconditional branches from word 0 to 20
        for (int c = 0; c < 9; c++) begin
            int tgt;
            tgt = (bt[c].taken != 0) ? 20 : 1;
            rom[0] = mk(0, bt[c].op, 20);
            prog_start(0, 0);
            ex(tgt, 0, bt[c].flg);
            ex(tgt + 1, tgt);
            prog_end(0);
            run_vecs($sformatf("branch%0d", c));
        end

        // Counted loop: word 49 runs four times, then exit to 51
        prog_start(48, 0);
        for (int k = 0; k < 10; k++) ex((k < 9) ? loop_tr[k + 1] : 52, loop_tr[k]);
        prog_end(0);
        run_vecs("loop");
        chk("loop.cnt_final", 32'(dut.cnt), 32'd0);

        // Subroutine call and return
        prog_start(10, 0);
        ex(30, 10); ex(11, 30); ex(12, 11);
        prog_end(0);
        run_vecs("sub");

        // Illegal op; then start with abort in IDLE is refused and err persists
        prog_start(40, 0);
        ex(-1, 40);
        prog_end(1);
        add(1, 5, 1, 0, 0, 0, 1, -1, -1);
        add(0, 0, 0, 0, 0, 0, 1, 0, -1);
        run_vecs("illegal");

        // Five nested calls overflow a 4-deep stack; reset in IDLE clears err
        prog_start(56, 1);
        ex(57, 56); ex(58, 57); ex(59, 58); ex(60, 59);
        ex(-1, 60);
        prog_end(1);
        add(0, 0, 0, 0, 0, 0, 1, 0, -1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, -1);
        run_vecs("nested");

        // Return with an empty stack
        prog_start(45, 0);
        ex(-1, 45);
        prog_end(1);
        run_vecs("ret_empty");

        // Abort in third EXEC cycle beats HALT; restart one cycle later
        prog_start(5, 1);
        ex(6, 5); ex(7, 6);
        add(0, 0, 1, 0, 1, 0, 0, -1, -1);
        add(0, 0, 0, 0, 0, 0, 0, 0, -1);
        prog_start(5, 0);
        ex(6, 5); ex(7, 6); ex(8, 7);
        prog_end(0);
        run_vecs("abort");

        // Reset in the middle of the loop
        prog_start(48, 0);
        ex(49, 48); ex(50, 49); ex(49, 50);
        add(0, 0, 0, 0, 1, 0, 0, 50, 49, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, -1);
        add(0, 0, 0, 0, 0, 0, 0, 0, -1);
        run_vecs("rst_mid");
        chk("rst_mid.cnt", 32'(dut.cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
